// File: rtl/fft_sdf_sequencer_if.sv
// Control bundle between the SDF FFT sequencer and its pipeline stages.
// The master side supplies in_valid; the slave side (the sequencer) drives the stage controls.
interface fft_sdf_sequencer_if #(
    parameter int LOG2N = 5,
    parameter int TWW   = 4
);
    logic                   in_valid;
    logic [LOG2N-1:0]       stage_en;
    logic [LOG2N-1:0]       stage_mode;
    logic [LOG2N*TWW-1:0]   tw_idx;
    logic                   out_valid;
    logic [LOG2N-1:0]       out_idx;
    logic                   busy;

    modport master (
        output in_valid,
        input  stage_en, stage_mode, tw_idx, out_valid, out_idx, busy
    );

    modport slave (
        input  in_valid,
        output stage_en, stage_mode, tw_idx, out_valid, out_idx, busy
    );
endinterface

// File: rtl/fft_sdf_sequencer.sv
// Single timing source for a radix-2 SDF DIF FFT: per-stage enable/mode/twiddle index,
// fill/drain tracking and bit-reversed output bin tagging.
//
// state | meaning
// IDLE  | no samples in flight, counters held at 0
// RUN   | samples arriving contiguously
// FLUSH | input paused, pipeline draining (restart allowed without losing g)
module fft_sdf_sequencer #(
    parameter int N     = 32,
    parameter int LOG2N = 5,
    parameter int TWW   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    fft_sdf_sequencer_if.slave sif
);
    localparam int L = N - 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t             state_q, state_d;
    logic [LOG2N-1:0]   g_q, g_d;
    logic [5:0]         age_q, age_d;
    logic [L-1:0]       vpipe_q, vpipe_d;

    logic               busy_w;
    logic [LOG2N-1:0]   en_w;
    logic [LOG2N-1:0]   mode_w;
    logic [LOG2N*TWW-1:0] tw_w;
    logic [LOG2N-1:0]   c;
    logic [LOG2N-1:0]   out_g;
    logic [LOG2N-1:0]   rev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            g_q     <= '0;
            age_q   <= '0;
            vpipe_q <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            age_q   <= age_d;
            vpipe_q <= vpipe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        age_d   = age_q;
        vpipe_d = {vpipe_q[L-2:0], sif.in_valid};
        case (state_q)
            S_IDLE: begin
                g_d   = '0;
                age_d = '0;
                if (sif.in_valid) begin
                    state_d = S_RUN;
                    g_d     = LOG2N'(1);
                    age_d   = 6'd1;
                end
            end
            S_RUN: begin
                g_d   = g_q + LOG2N'(1);
                age_d = (age_q == 6'd63) ? age_q : age_q + 6'd1;
                if (!sif.in_valid) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                g_d   = g_q + LOG2N'(1);
                age_d = (age_q == 6'd63) ? age_q : age_q + 6'd1;
                // A new sample wins over the drain-complete condition.
                if (sif.in_valid) begin
                    state_d = S_RUN;
                end else if (vpipe_d == '0) begin
                    state_d = S_IDLE;
                    g_d     = '0;
                    age_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_w = (state_q != S_IDLE);

    // Stage s sees the frame OFF_s cycles late; its delay line length D_s sets the mode bit.
    always_comb begin
        en_w   = '0;
        mode_w = '0;
        tw_w   = '0;
        c      = '0;
        for (int s = 0; s < LOG2N; s++) begin
            c         = g_q - LOG2N'(N - (N >> s));
            en_w[s]   = busy_w && (age_q > 6'(N - (N >> s)));
            mode_w[s] = c[LOG2N-1-s];
            if (!mode_w[s] && en_w[s])
                tw_w[s*TWW +: TWW] = TWW'((c & LOG2N'((N >> (s + 1)) - 1)) << s);
        end
    end

    always_comb begin
        rev   = '0;
        out_g = g_q - LOG2N'(L);
        for (int i = 0; i < LOG2N; i++) rev[i] = out_g[LOG2N-1-i];
    end

    assign sif.busy       = busy_w;
    assign sif.stage_en   = en_w;
    assign sif.stage_mode = mode_w;
    assign sif.tw_idx     = tw_w;
    assign sif.out_valid  = vpipe_q[L-1];
    assign sif.out_idx    = vpipe_q[L-1] ? rev : '0;
endmodule

// File: tb/tb_fft_sdf_sequencer.sv
// Scoreboard bench for fft_sdf_sequencer: stimulus queues expected bins and due cycles,
// an independent monitor retires them against out_valid/out_idx.
module tb_fft_sdf_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_sdf_sequencer_if #(.LOG2N(5), .TWW(4)) sif ();

    fft_sdf_sequencer #(.N(32), .LOG2N(5), .TWW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif)
    );

    typedef struct {
        logic [4:0] idx;
        int         due;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   last_cyc = 0;
    int   offs[5] = '{0, 16, 24, 28, 30};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4:0] brev(input int p);
        logic [4:0] v;
        logic [4:0] r;
        v = p[4:0];
        for (int i = 0; i < 5; i++) r[i] = v[4-i];
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: retire scoreboard entries when the DUT presents output.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (sif.out_valid) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_out: got out_valid=1 idx=%0d, expected no output (cycle %0d)",
                             sif.out_idx, cyc);
                end else begin
                    e = sbq.pop_front();
                    check("out_idx", int'(sif.out_idx), int'(e.idx));
                    check("out_cycle", cyc, e.due);
                end
            end else begin
                check("idle_out_idx", int'(sif.out_idx), 0);
                if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                    e = sbq.pop_front();
                    check("missing_out", 0, 1);
                end
            end
        end
    end

    task automatic drive(input bit v, input int pos);
        @(negedge clk);
        sif.in_valid = v;
        if (v) begin
            sbq.push_back('{idx: brev(pos), due: cyc + 31});
            last_cyc = cyc;
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_busy"}, int'(sif.busy), 0);
        check({tag, "_stage_en"}, int'(sif.stage_en), 0);
        check({tag, "_stage_mode"}, int'(sif.stage_mode), 0);
        check({tag, "_tw_idx"}, int'(sif.tw_idx), 0);
        check({tag, "_out_valid"}, int'(sif.out_valid), 0);
        check({tag, "_out_idx"}, int'(sif.out_idx), 0);
    endtask

    // Frame from IDLE: cycle k of the frame has age=k, g=k.
    task automatic frame_from_idle(input int skip, input bit chk_stage);
        logic [4:0] en_exp;
        for (int p = 0; p < 32; p++) begin
            drive(p != skip, p);
            if (chk_stage) begin
                for (int s = 0; s < 5; s++) en_exp[s] = (p > offs[s]);
                check("stage_en", int'(sif.stage_en), int'(en_exp));
                check("mode0", int'(sif.stage_mode[0]), (p >= 16) ? 1 : 0);
                check("tw0", int'(sif.tw_idx[3:0]), (p < 16) ? p : 0);
                if (p == 30) check("en4_at_age30", int'(sif.stage_en[4]), 0);
                if (p == 31) check("en4_at_age31", int'(sif.stage_en[4]), 1);
            end
        end
    endtask

    task automatic finish_run(input bit chk_drop);
        int n;
        int tl;
        n  = 0;
        tl = last_cyc;
        @(negedge clk);
        sif.in_valid = 1'b0;
        while (sif.busy && n < 200) begin
            if (chk_drop && cyc == tl + 31) check("busy_at_t31", int'(sif.busy), 1);
            @(negedge clk);
            n++;
        end
        check("busy_low", int'(sif.busy), 0);
        if (chk_drop) check("busy_drop_cycle", cyc, tl + 32);
        repeat (3) @(negedge clk);
        check("sb_empty", sbq.size(), 0);
        sbq.delete();
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        sif.in_valid = 1'b0;
        #1;
        chk_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame with stage-0/stage-enable checks
        frame_from_idle(-1, 1'b1);
        finish_run(1'b1);

        // Back-to-back frames
        for (int p = 0; p < 64; p++) begin
            drive(1'b1, p);
            if (p > 0) check("b2b_busy", int'(sif.busy), 1);
        end
        finish_run(1'b1);

        // Bubble at frame sample 5
        frame_from_idle(5, 1'b0);
        finish_run(1'b1);

        // Async reset at frame sample 20
        for (int p = 0; p < 20; p++) drive(1'b1, p);
        @(negedge clk);
        sif.in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        sbq.delete();
        sif.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("held_reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        frame_from_idle(-1, 1'b1);
        finish_run(1'b1);

        // Restart from FLUSH after 10 idle cycles
        for (int p = 0; p < 32; p++) drive(1'b1, p);
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 0);
            check("flush_busy", int'(sif.busy), 1);
        end
        drive(1'b1, 10);
        check("restart_busy", int'(sif.busy), 1);
        check("restart_tw0_g10", int'(sif.tw_idx[3:0]), 10);
        for (int p = 11; p < 32; p++) begin
            drive(1'b1, p);
            check("restart_run_busy", int'(sif.busy), 1);
        end
        finish_run(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
